// File: rtl/dii_package.sv
// Debug interconnect shared types: ring flit, link flit and link word width.
package dii_package;

  // Ring channel flit as carried on the debug ring.
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  // Tagged word carried on the inter-tile debug link.
  typedef struct packed {
    logic        valid;
    logic        chan;
    logic        last;
    logic [15:0] data;
  } dii_link_flit;

  localparam int unsigned DII_LINK_W = 19;

  // Even parity bit covering the tagged payload of a link word.
  function automatic logic link_word_parity(input logic        chan,
                                            input logic        last,
                                            input logic [15:0] data);
    return ^{chan, last, data};
  endfunction

endpackage

// File: rtl/dii_link_credit.sv
// Per-channel credit counter for the debug link transmitter.
// Starts full; a consumed flit takes one credit, a return pulse gives one
// back. A return while already full saturates and raises overflow_o.
module dii_link_credit #(
  parameter int unsigned CREDITS = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic consume_i,
  input  logic return_i,
  output logic nonzero_o,
  output logic overflow_o
);

  localparam int unsigned      CNT_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(CREDITS);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;

  // Next credit count; simultaneous consume and return cancel out.
  always_comb begin
    count_d    = count_q;
    overflow_o = 1'b0;
    unique case ({consume_i, return_i})
      2'b10: count_d = count_q - ONE;
      2'b01: begin
        if (count_q == FULL) begin
          overflow_o = 1'b1;
        end else begin
          count_d = count_q + ONE;
        end
      end
      default: ;
    endcase
  end

  // Credit count register, full after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= FULL;
    end else begin
      count_q <= count_d;
    end
  end

  assign nonzero_o = (count_q != '0);

endmodule

// File: rtl/debug_ring_link_tx.sv
// Transmit end of the debug link: merges the two ring extension channels
// onto one registered, channel-tagged link word. Round-robin arbitration
// with the grant held for a whole packet; credit-based flow control.
// Optional: DEBUG_RING_LINK_PARITY_EN adds a registered even-parity bit.
module debug_ring_link_tx
  import dii_package::*;
#(
  parameter int unsigned CREDITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  dii_flit      [1:0] ring_in,
  output logic         [1:0] ring_in_ready,
  output dii_link_flit       link_out,
  output logic               link_parity,
  input  logic         [1:0] credit_ret,
  output logic               credit_err
);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_e;

  state_e       state_q, state_d;
  logic         lock_chan_q, lock_chan_d;
  logic         rr_ptr_q, rr_ptr_d;
  dii_link_flit link_q, link_d;
  logic         err_q, err_d;

  logic [1:0] nonzero;
  logic [1:0] overflow;
  logic [1:0] eligible;
  logic [1:0] consume;
  logic       grant_vld;
  logic       grant_chan;
  logic       xfer_vld;
  logic       xfer_chan;
  dii_flit    xfer_flit;

  dii_link_credit #(.CREDITS(CREDITS)) u_credit0 (
    .clk_i      (clk),
    .rst_i      (rst),
    .consume_i  (consume[0]),
    .return_i   (credit_ret[0]),
    .nonzero_o  (nonzero[0]),
    .overflow_o (overflow[0])
  );

  dii_link_credit #(.CREDITS(CREDITS)) u_credit1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .consume_i  (consume[1]),
    .return_i   (credit_ret[1]),
    .nonzero_o  (nonzero[1]),
    .overflow_o (overflow[1])
  );

  // Grant selection, per-channel ready and the resulting transfer.
  always_comb begin
    eligible[0] = ring_in[0].valid && nonzero[0];
    eligible[1] = ring_in[1].valid && nonzero[1];
    grant_vld   = 1'b0;
    grant_chan  = 1'b0;
    if (state_q == ST_LOCKED) begin
      grant_vld  = 1'b1;
      grant_chan = lock_chan_q;
    end else if (&eligible) begin
      grant_vld  = 1'b1;
      grant_chan = rr_ptr_q;
    end else if (eligible[0]) begin
      grant_vld  = 1'b1;
      grant_chan = 1'b0;
    end else if (eligible[1]) begin
      grant_vld  = 1'b1;
      grant_chan = 1'b1;
    end
    // Ready is also held low while reset is asserted.
    ring_in_ready = '0;
    if (grant_vld && !rst) begin
      ring_in_ready[grant_chan] = nonzero[grant_chan];
    end
    xfer_chan = grant_chan;
    xfer_flit = ring_in[grant_chan];
    xfer_vld  = xfer_flit.valid && ring_in_ready[grant_chan];
    consume   = '0;
    if (xfer_vld) begin
      consume[xfer_chan] = 1'b1;
    end
  end

  // Packet lock state machine and round-robin pointer update.
  always_comb begin
    state_d     = state_q;
    lock_chan_d = lock_chan_q;
    rr_ptr_d    = rr_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer_vld) begin
          if (xfer_flit.last) begin
            rr_ptr_d = ~xfer_chan;
          end else begin
            state_d     = ST_LOCKED;
            lock_chan_d = xfer_chan;
          end
        end
      end
      ST_LOCKED: begin
        if (xfer_vld && xfer_flit.last) begin
          state_d  = ST_IDLE;
          rr_ptr_d = ~lock_chan_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Link word: loads on transfer, otherwise only valid drops.
  always_comb begin
    link_d       = link_q;
    link_d.valid = 1'b0;
    if (xfer_vld) begin
      link_d.valid = 1'b1;
      link_d.chan  = xfer_chan;
      link_d.last  = xfer_flit.last;
      link_d.data  = xfer_flit.data;
    end
    err_d = err_q | (|overflow);
  end

  // State, link word and sticky credit error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lock_chan_q <= 1'b0;
      rr_ptr_q    <= 1'b0;
      link_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_chan_q <= lock_chan_d;
      rr_ptr_q    <= rr_ptr_d;
      link_q      <= link_d;
      err_q       <= err_d;
    end
  end

  assign link_out   = link_q;
  assign credit_err = err_q;

`ifdef DEBUG_RING_LINK_PARITY_EN
  logic parity_q;

  // Parity travels with the link word and only changes on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (xfer_vld) begin
      parity_q <= link_word_parity(xfer_chan, xfer_flit.last, xfer_flit.data);
    end
  end

  assign link_parity = parity_q;
`else
  assign link_parity = 1'b0;
`endif

endmodule

// File: tb/tb_debug_ring_link_tx.sv
// Bench for debug_ring_link_tx: queued packet sources, credit return
// generation and a transaction-level reference model.
module tb_debug_ring_link_tx;
  import dii_package::*;

  localparam int CREDITS = 4;
`ifdef DEBUG_RING_LINK_PARITY_EN
  localparam logic EXP_T6_PARITY = 1'b1;
`else
  localparam logic EXP_T6_PARITY = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  dii_flit      [1:0] ring_in;
  logic         [1:0] ring_in_ready;
  dii_link_flit       link_out;
  logic               link_parity;
  logic         [1:0] credit_ret;
  logic               credit_err;

  always #5 clk = ~clk;

  debug_ring_link_tx #(.CREDITS(CREDITS)) dut (
    .clk           (clk),
    .rst           (rst),
    .ring_in       (ring_in),
    .ring_in_ready (ring_in_ready),
    .link_out      (link_out),
    .link_parity   (link_parity),
    .credit_ret    (credit_ret),
    .credit_err    (credit_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: credits as plain integers, owner of the open packet
  // (-1 when none), preferred channel for the next tie.
  int           m_credit[2];
  int           m_owner;
  int           m_pref;
  dii_link_flit m_link;
  logic         m_par;
  logic         m_err;

  // Packet sources: one flit queue per channel; pres = head is on the bus.
  dii_flit q[2][$];
  logic    pres[2];

  task automatic model_reset();
    m_credit[0] = CREDITS;
    m_credit[1] = CREDITS;
    m_owner     = -1;
    m_pref      = 0;
    m_link      = '0;
    m_par       = 1'b0;
    m_err       = 1'b0;
  endtask

  task automatic push_pkt(input int c, input int n, input int base);
    dii_flit f;
    for (int i = 0; i < n; i++) begin
      f.valid = 1'b1;
      f.last  = (i == n - 1);
      f.data  = 16'(base + i);
      q[c].push_back(f);
    end
  endtask

  // One clock cycle: apply inputs, check ready, clock, check outputs.
  task automatic step(input dii_flit [1:0] in, input logic [1:0] cret,
                      output logic [1:0] rdy_seen);
    logic [1:0] er;
    logic [1:0] el;
    int         xc;
    ring_in    = in;
    credit_ret = cret;
    #1;
    er = '0;
    for (int c = 0; c < 2; c++) el[c] = in[c].valid && (m_credit[c] > 0);
    if (m_owner >= 0)       er[m_owner] = (m_credit[m_owner] > 0);
    else if (el == 2'b11)   er[m_pref]  = 1'b1;
    else if (el[0])         er[0]       = 1'b1;
    else if (el[1])         er[1]       = 1'b1;
    check_eq("ready", 32'(ring_in_ready), 32'(er));
    rdy_seen = ring_in_ready;
    xc = -1;
    for (int c = 0; c < 2; c++) if (in[c].valid && er[c]) xc = c;
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      m_credit[c] = m_credit[c] + int'(cret[c]) - ((xc == c) ? 1 : 0);
      if (m_credit[c] > CREDITS) begin
        m_credit[c] = CREDITS;
        m_err       = 1'b1;
      end
    end
    m_link.valid = 1'b0;
    if (xc >= 0) begin
      m_link.valid = 1'b1;
      m_link.chan  = xc[0];
      m_link.last  = in[xc].last;
      m_link.data  = in[xc].data;
`ifdef DEBUG_RING_LINK_PARITY_EN
      m_par = 1'(($countones(in[xc].data) + xc + int'(in[xc].last)) % 2);
`endif
      if (in[xc].last) begin
        m_owner = -1;
        m_pref  = 1 - xc;
      end else begin
        m_owner = xc;
      end
    end
    #1;
    check_eq("link_out", 32'(link_out), 32'(m_link));
    check_eq("link_parity", 32'(link_parity), 32'(m_par));
    check_eq("credit_err", 32'(credit_err), 32'(m_err));
  endtask

  // Run ncyc cycles of the sources; returns on random cycles when the far
  // end holds flits, plus any forced return pulses.
  task automatic run(input int ncyc, input int ret_pct, input logic [1:0] force_ret,
                     input int gap_pct);
    dii_flit [1:0] in;
    logic    [1:0] cret;
    logic    [1:0] rdy;
    for (int n = 0; n < ncyc; n++) begin
      in   = '0;
      cret = force_ret;
      for (int c = 0; c < 2; c++) begin
        if (!pres[c] && q[c].size() > 0 && $urandom_range(0, 99) >= gap_pct) pres[c] = 1'b1;
        if (pres[c]) in[c] = q[c][0];
        if (ret_pct > 0 && m_credit[c] < CREDITS && $urandom_range(0, 99) < ret_pct)
          cret[c] = 1'b1;
      end
      step(in, cret, rdy);
      for (int c = 0; c < 2; c++) begin
        if (pres[c] && rdy[c]) begin
          void'(q[c].pop_front());
          pres[c] = 1'b0;
        end
      end
    end
  endtask

  // Asynchronous reset, asserted away from the clock edge.
  task automatic do_reset();
    dii_flit f;
    f.valid = 1'b1;
    f.last  = 1'b0;
    f.data  = 16'hBEEF;
    rst        = 1'b1;
    ring_in    = {f, f};
    credit_ret = '0;
    #1;
    check_eq("rst_ready", 32'(ring_in_ready), 32'd0);
    check_eq("rst_link_out", 32'(link_out), 32'd0);
    check_eq("rst_parity", 32'(link_parity), 32'd0);
    check_eq("rst_credit_err", 32'(credit_err), 32'd0);
    model_reset();
    q[0].delete();
    q[1].delete();
    pres[0] = 1'b0;
    pres[1] = 1'b0;
    @(posedge clk);
    #1;
    ring_in = '0;
    rst     = 1'b0;
  endtask

  initial begin
    ring_in    = '0;
    credit_ret = '0;
    do_reset();

    // ch0 three-flit packet, ch1 idle; one credit left afterwards
    push_pkt(0, 3, 16'h0A01);
    run(5, 0, 2'b00, 0);
    check_eq("t1_q0_sent", 32'(q[0].size()), 32'd0);
    push_pkt(0, 3, 16'h0B00);
    run(4, 0, 2'b00, 0);
    check_eq("t1_one_credit", 32'(q[0].size()), 32'd2);

    // both channels start a two-flit packet together
    do_reset();
    push_pkt(0, 2, 16'h1000);
    push_pkt(1, 2, 16'h2000);
    run(6, 0, 2'b00, 0);
    check_eq("t2_q0_sent", 32'(q[0].size()), 32'd0);
    check_eq("t2_q1_sent", 32'(q[1].size()), 32'd0);

    // ch1 six-flit packet runs out of credits, ch0 waits behind it
    do_reset();
    push_pkt(1, 6, 16'h3000);
    run(1, 0, 2'b00, 0);
    push_pkt(0, 2, 16'h4000);
    run(7, 0, 2'b00, 0);
    check_eq("t3_q1_stalled", 32'(q[1].size()), 32'd2);
    check_eq("t3_q0_blocked", 32'(q[0].size()), 32'd2);
    run(1, 0, 2'b10, 0);
    run(2, 0, 2'b00, 0);
    check_eq("t3_one_released", 32'(q[1].size()), 32'd1);
    check_eq("t3_q0_still", 32'(q[0].size()), 32'd2);
    run(1, 0, 2'b10, 0);
    run(2, 0, 2'b00, 0);
    check_eq("t3_q1_done", 32'(q[1].size()), 32'd0);
    run(4, 0, 2'b00, 0);
    check_eq("t3_q0_done", 32'(q[0].size()), 32'd0);

    // transfer and credit return in the same cycle at credit 2
    do_reset();
    push_pkt(0, 2, 16'h5000);
    run(3, 0, 2'b00, 0);
    push_pkt(0, 4, 16'h6000);
    run(1, 0, 2'b01, 0);
    run(4, 0, 2'b00, 0);
    check_eq("t4_credit_kept", 32'(q[0].size()), 32'd1);

    // return while full: sticky error, counter stays saturated
    do_reset();
    run(1, 0, 2'b01, 0);
    run(3, 0, 2'b00, 0);
    check_eq("t5_err_sticky", 32'(credit_err), 32'd1);
    push_pkt(0, 5, 16'h7000);
    run(7, 0, 2'b00, 0);
    check_eq("t5_credit_sat", 32'(q[0].size()), 32'd1);

    // parity on a ch1 last flit with data 0x0001
    do_reset();
    push_pkt(1, 1, 16'h0001);
    run(2, 0, 2'b00, 0);
    check_eq("t6_parity", 32'(link_parity), 32'(EXP_T6_PARITY));

    // reset in the middle of a packet releases the lock
    do_reset();
    push_pkt(0, 3, 16'h8000);
    run(2, 0, 2'b00, 0);
    do_reset();
    push_pkt(1, 1, 16'h9000);
    run(3, 0, 2'b00, 0);
    check_eq("t7_unlocked", 32'(q[1].size()), 32'd0);

    // randomized traffic with gaps and random credit returns
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < 2; c++)
        if (q[c].size() < 3) push_pkt(c, $urandom_range(1, 6), int'($urandom_range(0, 65535)));
      run(1, 35, 2'b00, 30);
    end
    run(80, 100, 2'b00, 0);
    check_eq("rand_q0_drained", 32'(q[0].size()), 32'd0);
    check_eq("rand_q1_drained", 32'(q[1].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
